// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store initiator with sub-word extraction and read-modify-write stores.
module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              memWrite,
    output logic              memRead,
    output logic [ADDR_W-1:0] address,
    output logic [31:0]       writedata,
    input  logic [31:0]       readdata
);
    typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, RESP, ERR} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              write_q, write_d;
    logic              uns_q, uns_d;
    logic [31:0]       data_q, data_d;
    logic              accept, misalign;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [31:0]       load_ext, merged;

    assign accept   = req_valid && state_q == IDLE;
    assign misalign = (req_size == 2'b01 && req_addr[0]) ||
                      (req_size == 2'b10 && req_addr[1:0] != 2'b00) ||
                      req_size == 2'b11;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
            uns_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            write_q <= write_d;
            uns_q   <= uns_d;
            data_q  <= data_d;
        end
    end

    // data_q holds store data until RD/RMW_RD replace it with the extended load or merged word
    always_comb begin
        lane_b   = readdata[{addr_q[1:0], 3'b000} +: 8];
        lane_h   = addr_q[1] ? readdata[31:16] : readdata[15:0];
        load_ext = size_q == 2'b00 ? {{24{~uns_q & lane_b[7]}}, lane_b} :
                   size_q == 2'b01 ? {{16{~uns_q & lane_h[15]}}, lane_h} : readdata;
        merged   = readdata;
        if (size_q == 2'b00)
            merged[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
        else
            merged[{addr_q[1], 4'b0000} +: 16] = data_q[15:0];
        addr_d  = accept ? req_addr : addr_q;
        size_d  = accept ? req_size : size_q;
        write_d = accept ? req_write : write_q;
        uns_d   = accept ? req_unsigned : uns_q;
        data_d  = accept ? req_wdata :
                  state_q == RD ? load_ext :
                  state_q == RMW_RD ? merged : data_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:         if (accept) state_d = misalign ? ERR : !req_write ? RD :
                                                req_size == 2'b10 ? WR : RMW_RD;
            RD, WR:       state_d = RESP;
            RMW_RD:       state_d = RMW_WR;
            RMW_WR:       state_d = RESP;
            default:      state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = state_q == IDLE;
        memRead   = state_q == RD || state_q == RMW_RD;
        memWrite  = state_q == WR || state_q == RMW_WR;
        address   = (memRead || memWrite) ? {2'b00, addr_q[ADDR_W-1:2]} : '0;
        writedata = memWrite ? data_q : '0;
        rsp_valid = state_q == RESP || state_q == ERR;
        rsp_err   = state_q == ERR;
        rsp_rdata = (state_q == RESP && !write_q) ? data_q : '0;
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage load/store initiator that sits between the pipeline's EX/MEM register and `memory_data_memory`. It accepts one load or store request at a time and drives the word-wide memory port (`memWrite`, `memRead`, `address`, `writedata`, `readdata`). It performs little-endian byte and halfword extraction with sign or zero extension, and implements sub-word stores as read-modify-write. A `req_ready`/`rsp_valid` handshake is used to stall the pipeline.

## Interface
- ADDR_W, 32, width of the byte address and of the memory `address` port. Data width is fixed at 32.
- clk  in  1  rising-edge clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  the pipeline presents a request.
- req_ready  out  1  high only in IDLE; a request is accepted on an edge where `req_valid && req_ready`.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- req_unsigned  in  1  selects zero extension for byte/halfword loads; sign extension otherwise.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; the low byte or halfword is used for sub-word stores.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load data; 0 for stores, errors and whenever `rsp_valid` = 0.
- rsp_err  out  1  asserted with `rsp_valid` on a misaligned or illegal request.
- memWrite  out  1  memory write strobe; memory commits on the clk edge ending the cycle.
- memRead  out  1  memory read enable; `readdata` is combinational and valid in the same cycle.
- address  out  ADDR_W  word index = `req_addr >> 2`.
- writedata  out  32  full word to write.
- readdata  in  32  memory read data.

## Operation
- States: IDLE, RD, WR, RMW_RD, RMW_WR, RESP, ERR.
- On acceptance, the block latches `req_addr`, size, write, unsigned and wdata.
- Error check happens at acceptance:
  - halfword with `addr[0]`=1, word with `addr[1:0]`≠0, or size=11 → ERR.
  - No memory strobe is issued for an error.
- Load → RD:
  - `memRead`=1 with `address` driven; `readdata` is captured at the end of the cycle; → RESP.
- Word store → WR:
  - `memWrite`=1 with `writedata`=wdata; → RESP.
- Byte/halfword store → RMW_RD, then RMW_WR:
  - RMW_RD: `memRead`=1; the old word is captured.
  - RMW_WR: `memWrite`=1 with the merged word; → RESP.
- Lane mapping is little-endian:
  - byte at `addr[1:0]`=k occupies bits [8k+7:8k].
  - halfword with `addr[1]`=0 occupies [15:0]; with `addr[1]`=1 it occupies [31:16].
  - Merge replaces only the addressed lane; all other bits equal the captured word.
- Load extension: the selected lane is sign- or zero-extended per `req_unsigned`; word loads pass through.
- RESP: `rsp_valid`=1 and `rsp_rdata` driven; → IDLE.
- ERR: `rsp_valid`=1, `rsp_err`=1, `rsp_rdata`=0; → IDLE.
- `memRead` and `memWrite` are never high in the same cycle.
- `address` holds the latched word index throughout RMW; it is 0 in IDLE.

## Timing
- All outputs are registered or decoded from state. Reset values:
  - state IDLE, `req_ready`=1.
  - `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0.
  - `memWrite`=0, `memRead`=0, `address`=0, `writedata`=0.
- Latency for a request accepted at edge T (cycle T+1 is the first cycle after it):
  - load: `memRead` in T+1, `rsp_valid` in T+2.
  - word store: `memWrite` in T+1, `rsp_valid` in T+2.
  - sub-word store: `memRead` in T+1, `memWrite` in T+2, `rsp_valid` in T+3.
  - error: `rsp_valid`/`rsp_err` in T+1.
- `req_ready` is 0 from T+1 through the RESP/ERR cycle inclusive. It returns to 1 the cycle after RESP, so back-to-back requests are spaced by the op length plus one.
- `req_valid` while `req_ready`=0 is ignored; no request is queued.
- Asynchronous reset mid-operation:
  - `memWrite`/`memRead` drop immediately and the FSM returns to IDLE.
  - A write already committed at a prior edge stands.
  - An RMW interrupted in RMW_RD leaves memory unchanged.
- Address wrap: the word index is plain truncation `req_addr[ADDR_W-1:2]`; there is no bounds check.

## Test plan
- Word round trip:
  - sw addr 0x0, data 100 → `memWrite`=1, `address`=0, `writedata`=100 in T+1; `rsp_valid` in T+2.
  - lw addr 0x0 → `rsp_rdata`=100 in T+2.
- Signed/unsigned byte load: memory word 1 = 0x80FF1234.
  - lb addr 0x7 → 0xFFFFFF80.
  - lbu addr 0x6 → 0x000000FF.
  - lh addr 0x4 → 0x00001234.
- Sub-word store merge: word 1 = 0x11223344; sb addr 0x5, wdata 0xAA.
  - `memRead` in T+1, `memWrite` in T+2 with `writedata`=0x1122AA44.
  - Subsequent lw addr 0x4 → 0x1122AA44.
- Misaligned request: lw addr 0x2 → `rsp_valid`=`rsp_err`=1 and `rsp_rdata`=0 in T+1; `memRead`/`memWrite` stay 0.
  - Same for sh addr 0x3 and for size=11.
- Back-to-back with `req_valid` held high: `req_ready` drops after acceptance.
  - A second lw is accepted only in the cycle after RESP.
  - Exactly one `memRead` pulse per request.
- Reset mid-RMW: assert `reset_n`=0 during RMW_RD of sh addr 0x4.
  - Outputs go to 0 at once; `req_ready`=1 after release.
  - Word 1 is unchanged.
